// File: rtl/draw_sprite_anim_pkg.sv
// Shared VGA overlay package: sprite life-cycle states, debug/transparent
// colours and the registered pixel-sample record used by the pipeline.
package vga_pkg;

    localparam int HC_W = 11;                       // hcount/vcount width

    typedef enum logic [1:0] {
        HIDDEN = 2'd0,
        FLY    = 2'd1,
        HIT    = 2'd2,
        FALL   = 2'd3
    } sprite_state_t;

    localparam logic [11:0] DEBUG_BBOX_RGB  = 12'h0F0;
    localparam logic [11:0] TRANSPARENT_RGB = 12'hF00;

    // One pixel of the VGA stream as carried between pipeline stages.
    typedef struct packed {
        logic [HC_W-1:0] hcount;
        logic [HC_W-1:0] vcount;
        logic            hsync;
        logic            vsync;
        logic            hblnk;
        logic            vblnk;
        logic [11:0]     rgb;
    } vga_sample_t;

endpackage

// File: rtl/draw_sprite_anim_if.sv
// itf_vga: VGA timing + colour bundle passed between drawer stages.
// master drives the stream, slave consumes it.
interface itf_vga;
    import vga_pkg::*;

    logic [HC_W-1:0] hcount;
    logic [HC_W-1:0] vcount;
    logic            hsync;
    logic            vsync;
    logic            hblnk;
    logic            vblnk;
    logic [11:0]     rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprite_anim_fsm.sv
// sprite_anim_fsm: HIDDEN/FLY/HIT/FALL life cycle, fly-animation divider
// and hit hold counter.
// Ports: clk, rst (sync, high), new_frame, show, hit  ->  state, img_idx
// (ROM image number), hit_done (registered, high in the first FALL cycle).
module sprite_anim_fsm import vga_pkg::*; #(
    parameter int FRAMES    = 4,
    parameter int FRAME_DIV = 4,
    parameter int HIT_HOLD  = 30,
    parameter int FW        = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          new_frame,
    input  logic          show,
    input  logic          hit,
    output sprite_state_t state,
    output logic [FW-1:0] img_idx,
    output logic          hit_done
);
    localparam int AW = $clog2(FRAMES);
    localparam int DW = $clog2(FRAME_DIV + 1);
    localparam int HW = $clog2(HIT_HOLD + 1);

    sprite_state_t state_nxt;
    logic [AW-1:0] anim_idx, anim_nxt;
    logic [DW-1:0] div_ctr, div_nxt;
    logic [HW-1:0] hold_ctr, hold_nxt;
    logic          done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HIDDEN;
            anim_idx <= '0;
            div_ctr  <= '0;
            hold_ctr <= '0;
            hit_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            anim_idx <= anim_nxt;
            div_ctr  <= div_nxt;
            hold_ctr <= hold_nxt;
            hit_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        anim_nxt  = anim_idx;
        div_nxt   = div_ctr;
        hold_nxt  = hold_ctr;
        done_nxt  = 1'b0;
        // show low dominates everything, including a coincident hit
        if (!show) begin
            state_nxt = HIDDEN;
        end else begin
            case (state)
                HIDDEN: begin
                    state_nxt = FLY;        // hit on the same cycle is dropped
                    anim_nxt  = '0;
                    div_nxt   = '0;
                end
                FLY: begin
                    if (hit) begin
                        state_nxt = HIT;
                        hold_nxt  = '0;
                    end else if (new_frame) begin
                        if (div_ctr == DW'(FRAME_DIV - 1)) begin
                            div_nxt  = '0;
                            anim_nxt = anim_idx + 1'b1;   // FRAMES is 2^AW
                        end else begin
                            div_nxt  = div_ctr + 1'b1;
                        end
                    end
                end
                HIT: begin
                    if (new_frame) begin
                        if (hold_ctr == HW'(HIT_HOLD - 1)) begin
                            state_nxt = FALL;
                            done_nxt  = 1'b1;
                        end else begin
                            hold_nxt  = hold_ctr + 1'b1;
                        end
                    end
                end
                default: ;                  // FALL holds until show drops
            endcase
        end
    end

    assign img_idx = (state == FLY) ? FW'(anim_idx) : FW'(FRAMES);
endmodule

// File: rtl/template_rom.sv
// template_rom: synchronous ROM, one-cycle read latency.
// Ports: clk, addr (ADDR_WIDTH), data (DATA_WIDTH, registered).
module template_rom #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 12,
    parameter     DATA_PATH  = "DH_duck.dat"
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);
    logic [DATA_WIDTH-1:0] rom [2**ADDR_WIDTH];

    always_ff @(posedge clk)
        data <= rom[addr];
endmodule

// File: rtl/draw_sprite_anim.sv
// draw_sprite_anim: animated sprite overlay for the itf_vga chain.
// Ports: clk, rst (sync, high), new_frame, show, hit, direction,
// sprite_x/sprite_y (top-left), state, hit_done, in (itf_vga slave),
// out (itf_vga master). Every out.* field lags in.* by exactly 2 clk:
// stage 1 = ROM address/read + in-box flag + input sample,
// stage 2 = colour mux into out.
// Optional: define DRAW_SPRITE_BBOX_EN to paint a 1-pixel debug hitbox.
module draw_sprite_anim import vga_pkg::*; #(
    parameter int          SPRITE_W    = 64,
    parameter int          SPRITE_H    = 48,
    parameter int          FRAMES      = 4,
    parameter int          FRAME_DIV   = 4,
    parameter int          HIT_HOLD    = 30,
    parameter logic [11:0] TRANSPARENT = TRANSPARENT_RGB,
    parameter              DATA_PATH   = "DH_duck.dat"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_frame,
    input  logic        show,
    input  logic        hit,
    input  logic        direction,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    output logic [1:0]  state,
    output logic        hit_done,
    itf_vga.slave       in,
    itf_vga.master      out
);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam int FW = $clog2(FRAMES + 1);
    localparam int AW = FW + RW + CW;

    sprite_state_t fsm_state;
    logic [FW-1:0] img_idx;

    sprite_anim_fsm #(
        .FRAMES(FRAMES), .FRAME_DIV(FRAME_DIV), .HIT_HOLD(HIT_HOLD), .FW(FW)
    ) u_fsm (
        .clk(clk), .rst(rst), .new_frame(new_frame), .show(show), .hit(hit),
        .state(fsm_state), .img_idx(img_idx), .hit_done(hit_done)
    );

    assign state = fsm_state;

    // 12-bit box arithmetic so sprite_x + SPRITE_W never wraps.
    logic [11:0]   h12, v12, x12, y12;
    logic          in_box;
    logic [CW-1:0] col_raw, col;
    logic [RW-1:0] row_raw, row;
    logic [AW-1:0] rom_addr;
    logic [11:0]   rom_data;

    always_comb begin
        h12     = 12'(in.hcount);
        v12     = 12'(in.vcount);
        x12     = 12'(sprite_x);
        y12     = 12'(sprite_y);
        in_box  = (h12 >= x12) && (h12 < x12 + 12'(SPRITE_W)) &&
                  (v12 >= y12) && (v12 < y12 + 12'(SPRITE_H));
        col_raw = CW'(h12 - x12);
        row_raw = RW'(v12 - y12);
        col     = direction ? col_raw : CW'(SPRITE_W - 1) - col_raw;
        row     = (fsm_state == FALL) ? RW'(SPRITE_H - 1) - row_raw : row_raw;
        rom_addr = {img_idx, row, col};
    end

    // The ROM's read register doubles as the stage-1 address register.
    template_rom #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(12), .DATA_PATH(DATA_PATH)
    ) u_rom (
        .clk(clk), .addr(rom_addr), .data(rom_data)
    );

`ifdef DRAW_SPRITE_BBOX_EN
    logic on_edge, edge_q;
    assign on_edge = in_box && (fsm_state != HIDDEN) &&
                     (h12 == x12 || h12 == x12 + 12'(SPRITE_W - 1) ||
                      v12 == y12 || v12 == y12 + 12'(SPRITE_H - 1));
`endif

    vga_sample_t s1;
    logic        vis_q;

    // Stage 1: input sample and sprite-visibility flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            vis_q <= 1'b0;
`ifdef DRAW_SPRITE_BBOX_EN
            edge_q <= 1'b0;
`endif
        end else begin
            s1    <= '{in.hcount, in.vcount, in.hsync, in.vsync,
                       in.hblnk, in.vblnk, in.rgb};
            vis_q <= in_box && (fsm_state != HIDDEN);
`ifdef DRAW_SPRITE_BBOX_EN
            edge_q <= on_edge;
`endif
        end
    end

    // Stage 2: colour mux, timing forwarded unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= s1.hcount;
            out.vcount <= s1.vcount;
            out.hsync  <= s1.hsync;
            out.vsync  <= s1.vsync;
            out.hblnk  <= s1.hblnk;
            out.vblnk  <= s1.vblnk;
`ifdef DRAW_SPRITE_BBOX_EN
            if (edge_q)
                out.rgb <= DEBUG_BBOX_RGB;
            else
`endif
            if (vis_q && rom_data != TRANSPARENT)
                out.rgb <= rom_data;
            else
                out.rgb <= s1.rgb;
        end
    end
endmodule

// File: tb/tb_draw_sprite_anim.sv
// Directed bench for draw_sprite_anim (default parameters, ROM image
// written directly into the ROM array with known marker texels).
module tb_draw_sprite_anim;
    import vga_pkg::*;

`ifdef DRAW_SPRITE_BBOX_EN
    localparam bit BBOX = 1'b1;
`else
    localparam bit BBOX = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, new_frame, show, hit, direction;
    logic [9:0] sprite_x, sprite_y;
    logic [1:0] state;
    logic       hit_done;
    int         compared = 0;
    int         mismatched = 0;

    itf_vga vin ();
    itf_vga vout ();

    always #5 clk = ~clk;

    draw_sprite_anim #(.DATA_PATH("")) dut (
        .clk(clk), .rst(rst), .new_frame(new_frame), .show(show), .hit(hit),
        .direction(direction), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .state(state), .hit_done(hit_done), .in(vin), .out(vout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel and return the colour it produces 2 clk later.
    task automatic px(input int h, input int v, input logic [11:0] c,
                      output logic [11:0] obs);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.rgb    = c;
        step();
        step();
        obs = vout.rgb;
    endtask

    task automatic pulse_nf();
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
    endtask

    function automatic int ra(input int img, input int row, input int col);
        return img * 4096 + row * 64 + col;
    endfunction

    task automatic load_rom();
        for (int a = 0; a < 32768; a++) dut.u_rom.rom[a] = 12'h5A5;
        dut.u_rom.rom[ra(0, 0, 0)]   = 12'hA01;
        dut.u_rom.rom[ra(0, 47, 63)] = 12'hA02;
        dut.u_rom.rom[ra(0, 1, 63)]  = 12'hA03;
        dut.u_rom.rom[ra(0, 1, 62)]  = 12'hA06;
        dut.u_rom.rom[ra(0, 10, 5)]  = 12'hF00;
        dut.u_rom.rom[ra(0, 1, 1)]   = 12'hB00;
        dut.u_rom.rom[ra(1, 1, 1)]   = 12'hB01;
        dut.u_rom.rom[ra(2, 1, 1)]   = 12'hB02;
        dut.u_rom.rom[ra(3, 1, 1)]   = 12'hB03;
        dut.u_rom.rom[ra(4, 1, 1)]   = 12'hC01;
        dut.u_rom.rom[ra(4, 47, 1)]  = 12'hC02;
        dut.u_rom.rom[ra(4, 46, 1)]  = 12'hC03;
    endtask

    task automatic test_reset();
        rst = 1'b1; new_frame = 1'b0; show = 1'b0; hit = 1'b0; direction = 1'b1;
        sprite_x = 10'd100; sprite_y = 10'd50;
        vin.hcount = 11'd9; vin.vcount = 11'd3; vin.rgb = 12'h777;
        vin.hsync = 1'b1; vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
        repeat (3) step();
        compared++; if (vout.rgb !== 12'h000) begin mismatched++; $display("FAIL rst_rgb got %h want 000", vout.rgb); end
        compared++; if (vout.hcount !== 11'd0) begin mismatched++; $display("FAIL rst_hcount got %0d want 0", vout.hcount); end
        compared++; if (vout.hsync !== 1'b0) begin mismatched++; $display("FAIL rst_hsync got %b want 0", vout.hsync); end
        compared++; if (state !== 2'd0) begin mismatched++; $display("FAIL rst_state got %0d want 0", state); end
        compared++; if (hit_done !== 1'b0) begin mismatched++; $display("FAIL rst_hit_done got %b want 0", hit_done); end
        vin.rgb = 12'h123; vin.hcount = 11'd5;
        rst = 1'b0;
        step();
        compared++; if (vout.rgb !== 12'h000) begin mismatched++; $display("FAIL post_rst_zero got %h want 000", vout.rgb); end
        step();
        compared++; if (vout.rgb !== 12'h123) begin mismatched++; $display("FAIL post_rst_rgb got %h want 123", vout.rgb); end
        compared++; if (vout.hcount !== 11'd5) begin mismatched++; $display("FAIL post_rst_hcount got %0d want 5", vout.hcount); end
    endtask

    task automatic test_idle_latency();
        for (int i = 0; i < 6; i++) begin
            vin.hcount = 11'(200 + i);
            vin.rgb    = 12'(12'h100 + i);
            step();
            if (i >= 1) begin
                compared++;
                if (vout.hcount !== 11'(200 + i - 1)) begin
                    mismatched++; $display("FAIL lat_hcount[%0d] got %0d want %0d", i, vout.hcount, 200 + i - 1);
                end
                compared++;
                if (vout.rgb !== 12'(12'h100 + i - 1)) begin
                    mismatched++; $display("FAIL lat_rgb[%0d] got %h want %h", i, vout.rgb, 12'(12'h100 + i - 1));
                end
            end
        end
    endtask

    task automatic test_box_edges();
        logic [11:0] obs, exp;
        show = 1'b1;
        step();
        compared++; if (state !== 2'd1) begin mismatched++; $display("FAIL show_fly got %0d want 1", state); end
        px(100, 50, 12'h321, obs); exp = BBOX ? 12'h0F0 : 12'hA01;
        compared++; if (obs !== exp) begin mismatched++; $display("FAIL box_tl got %h want %h", obs, exp); end
        px(163, 97, 12'h321, obs); exp = BBOX ? 12'h0F0 : 12'hA02;
        compared++; if (obs !== exp) begin mismatched++; $display("FAIL box_br got %h want %h", obs, exp); end
        px(99, 50, 12'h321, obs);
        compared++; if (obs !== 12'h321) begin mismatched++; $display("FAIL box_left_out got %h want 321", obs); end
        px(164, 50, 12'h321, obs);
        compared++; if (obs !== 12'h321) begin mismatched++; $display("FAIL box_right_out got %h want 321", obs); end
        px(100, 98, 12'h321, obs);
        compared++; if (obs !== 12'h321) begin mismatched++; $display("FAIL box_below_out got %h want 321", obs); end
        px(105, 60, 12'h3C3, obs);
        compared++; if (obs !== 12'h3C3) begin mismatched++; $display("FAIL transparent got %h want 3c3", obs); end
        px(101, 51, 12'h321, obs);
        compared++; if (obs !== 12'hB00) begin mismatched++; $display("FAIL interior got %h want b00", obs); end
    endtask

    task automatic test_animation();
        logic [11:0] obs, exp;
        for (int p = 0; p <= 16; p++) begin
            if (p > 0) pulse_nf();
            px(101, 51, 12'h321, obs);
            exp = 12'(12'hB00 + (p / 4) % 4);
            compared++;
            if (obs !== exp) begin mismatched++; $display("FAIL anim[%0d] got %h want %h", p, obs, exp); end
        end
        direction = 1'b0;
        px(100, 51, 12'h321, obs); exp = BBOX ? 12'h0F0 : 12'hA03;
        compared++; if (obs !== exp) begin mismatched++; $display("FAIL mirror_col63 got %h want %h", obs, exp); end
        px(101, 51, 12'h321, obs);
        compared++; if (obs !== 12'hA06) begin mismatched++; $display("FAIL mirror_col62 got %h want a06", obs); end
        direction = 1'b1;
    endtask

    task automatic test_hit();
        logic [11:0] obs, exp;
        hit = 1'b1; step(); hit = 1'b0;
        compared++; if (state !== 2'd2) begin mismatched++; $display("FAIL hit_state got %0d want 2", state); end
        px(101, 51, 12'h321, obs);
        compared++; if (obs !== 12'hC01) begin mismatched++; $display("FAIL hit_frame got %h want c01", obs); end
        repeat (10) pulse_nf();
        hit = 1'b1; step(); hit = 1'b0;   // must not restart the hold count
        compared++; if (state !== 2'd2) begin mismatched++; $display("FAIL rehit_state got %0d want 2", state); end
        repeat (19) pulse_nf();
        compared++; if (state !== 2'd2) begin mismatched++; $display("FAIL hold29_state got %0d want 2", state); end
        compared++; if (hit_done !== 1'b0) begin mismatched++; $display("FAIL hold29_done got %b want 0", hit_done); end
        new_frame = 1'b1; step(); new_frame = 1'b0;
        compared++; if (state !== 2'd3) begin mismatched++; $display("FAIL fall_state got %0d want 3", state); end
        compared++; if (hit_done !== 1'b1) begin mismatched++; $display("FAIL hit_done_pulse got %b want 1", hit_done); end
        step();
        compared++; if (hit_done !== 1'b0) begin mismatched++; $display("FAIL hit_done_clear got %b want 0", hit_done); end
        px(101, 51, 12'h321, obs);
        compared++; if (obs !== 12'hC03) begin mismatched++; $display("FAIL fall_row46 got %h want c03", obs); end
        px(101, 50, 12'h321, obs); exp = BBOX ? 12'h0F0 : 12'hC02;
        compared++; if (obs !== exp) begin mismatched++; $display("FAIL fall_row47 got %h want %h", obs, exp); end
        compared++; if (state !== 2'd3) begin mismatched++; $display("FAIL fall_hold got %0d want 3", state); end
    endtask

    task automatic test_priority();
        logic [11:0] obs;
        show = 1'b0; step();
        compared++; if (state !== 2'd0) begin mismatched++; $display("FAIL hide_state got %0d want 0", state); end
        px(101, 51, 12'h456, obs);
        compared++; if (obs !== 12'h456) begin mismatched++; $display("FAIL hidden_pass got %h want 456", obs); end
        hit = 1'b1; step();
        compared++; if (state !== 2'd0) begin mismatched++; $display("FAIL hit_hidden got %0d want 0", state); end
        show = 1'b1; step(); hit = 1'b0;
        compared++; if (state !== 2'd1) begin mismatched++; $display("FAIL show_hit_fly got %0d want 1", state); end
        repeat (4) pulse_nf();
        px(101, 51, 12'h321, obs);
        compared++; if (obs !== 12'hB01) begin mismatched++; $display("FAIL anim1 got %h want b01", obs); end
        show = 1'b0; hit = 1'b1; step(); hit = 1'b0;
        compared++; if (state !== 2'd0) begin mismatched++; $display("FAIL show0_over_hit got %0d want 0", state); end
        show = 1'b1; step();
        compared++; if (state !== 2'd1) begin mismatched++; $display("FAIL reenter_fly got %0d want 1", state); end
        px(101, 51, 12'h321, obs);
        compared++; if (obs !== 12'hB00) begin mismatched++; $display("FAIL anim_reset got %h want b00", obs); end
    endtask

    initial begin
        load_rom();
        test_reset();
        test_idle_latency();
        test_box_edges();
        test_animation();
        test_hit();
        test_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
